// File: rtl/coeff_load_sequencer_if.sv
// coeff_load_sequencer_if: APB-style write/read port of the coefficient register bank.
// Signals: PWRITE, PENABLE, DATA_ADDR, DATA_IN, FRAC_DECI_EN, IIR_EN, CIC_EN, CTRL_EN
// (driven by the sequencer), PREADY, PRDATA (driven by the bank).
// Modports: master = sequencer side, slave = bank side.
interface coeff_load_sequencer_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic                  PWRITE;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] DATA_ADDR;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  FRAC_DECI_EN;
    logic                  IIR_EN;
    logic                  CIC_EN;
    logic                  CTRL_EN;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        output PWRITE, PENABLE, DATA_ADDR, DATA_IN, FRAC_DECI_EN, IIR_EN, CIC_EN, CTRL_EN,
        input  PREADY, PRDATA
    );

    modport slave (
        input  PWRITE, PENABLE, DATA_ADDR, DATA_IN, FRAC_DECI_EN, IIR_EN, CIC_EN, CTRL_EN,
        output PREADY, PRDATA
    );
endinterface

// File: rtl/coeff_load_sequencer.sv
// coeff_load_sequencer: streams words from a valid/ready source into consecutive
// coefficient bank addresses over an APB-style port, with region-enable decode.
// Ports: clk, rst_n (async, active-low); start/base_addr/word_count/abort command;
// src_valid/src_data/src_ready source stream; bus (coeff_load_sequencer_if.master);
// busy/done/err_code/aborted/words_done status. All outputs are registered.
// Optional: define COEFF_LOAD_VERIFY_EN to read back and compare every written word.
module coeff_load_sequencer #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int TAPS        = 72,
    parameter int NUM_DENUM   = 5,
    parameter int MAX_ADDR    = 95,
    parameter int TIMEOUT_CYC = 16,
    parameter int COEFF_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  abort,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    coeff_load_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err_code,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   words_done
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_WIDTH-1:0] A_TAPS = ADDR_WIDTH'(TAPS);
    localparam logic [ADDR_WIDTH-1:0] A_CIC  = ADDR_WIDTH'(TAPS + 3 * NUM_DENUM);
    localparam logic [ADDR_WIDTH+1:0] A_END  = (ADDR_WIDTH+2)'(MAX_ADDR + 1);
    localparam logic [TW-1:0]         T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, SETUP, ACCESS, DONE
`ifdef COEFF_LOAD_VERIFY_EN
        , RD_SETUP, RD_ACCESS
`endif
    } state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] addr, addr_d;
    logic [ADDR_WIDTH:0]   cnt, cnt_d, wd_d;
    logic [DATA_WIDTH-1:0] data, data_d;
    logic [TW-1:0]         tmo, tmo_d;
    logic                  abort_p, abort_p_d, abt_d, ab;
    logic [1:0]            err_d;
    logic [ADDR_WIDTH+1:0] end_addr;
    logic                  range_err, rd_d, rd_acc_d, phase_d;

    // one past the last address; legal loads end at or below MAX_ADDR+1
    assign end_addr  = {2'b00, base_addr} + {1'b0, word_count};
    assign range_err = word_count != '0 && end_addr > A_END;
    // an abort seen during an access is remembered until that access resolves
    assign ab        = abort_p | abort;

`ifdef COEFF_LOAD_VERIFY_EN
    assign rd_d     = state_d == RD_SETUP || state_d == RD_ACCESS;
    assign rd_acc_d = state_d == RD_ACCESS;
`else
    logic unused_prdata;
    assign rd_d          = 1'b0;
    assign rd_acc_d      = 1'b0;
    assign unused_prdata = (^bus.PRDATA) ^ (^bus.PRDATA[COEFF_WIDTH-1:0]);
`endif

    assign phase_d = state_d == SETUP || state_d == ACCESS || rd_d;

    always_comb begin
        state_d   = state;
        addr_d    = addr;
        cnt_d     = cnt;
        data_d    = data;
        tmo_d     = tmo;
        abort_p_d = abort_p;
        err_d     = err_code;
        abt_d     = aborted;
        wd_d      = words_done;
        case (state)
            IDLE: if (start) begin
                err_d     = 2'd0;
                abt_d     = 1'b0;
                wd_d      = '0;
                abort_p_d = 1'b0;
                if (range_err) begin
                    err_d   = 2'd1;
                    state_d = DONE;
                end else begin
                    addr_d  = base_addr;
                    cnt_d   = word_count;
                    state_d = word_count == '0 ? DONE : FETCH;
                end
            end
            // abort beats a simultaneous src_valid: the word is not taken
            FETCH: if (abort) begin
                abt_d   = 1'b1;
                state_d = DONE;
            end else if (src_valid) begin
                data_d  = src_data;
                state_d = SETUP;
            end
            SETUP: begin
                tmo_d   = '0;
                abt_d   = abort;
                state_d = abort ? DONE : ACCESS;
            end
            ACCESS: begin
                abort_p_d = ab;
                tmo_d     = tmo + TW'(1);
                if (bus.PREADY) begin
                    wd_d  = words_done + (ADDR_WIDTH+1)'(1);
                    cnt_d = cnt - (ADDR_WIDTH+1)'(1);
                    abt_d = ab;
`ifdef COEFF_LOAD_VERIFY_EN
                    state_d = ab ? DONE : RD_SETUP;
`else
                    addr_d  = addr + ADDR_WIDTH'(1);
                    state_d = (ab || cnt_d == '0) ? DONE : FETCH;
`endif
                end else if (tmo == T_LAST) begin
                    err_d   = 2'd2;
                    abt_d   = ab;
                    state_d = DONE;
                end
            end
`ifdef COEFF_LOAD_VERIFY_EN
            RD_SETUP: begin
                abort_p_d = ab;
                tmo_d     = '0;
                state_d   = RD_ACCESS;
            end
            RD_ACCESS: begin
                abort_p_d = ab;
                tmo_d     = tmo + TW'(1);
                if (bus.PREADY) begin
                    abt_d = ab;
                    if (bus.PRDATA[COEFF_WIDTH-1:0] != data[COEFF_WIDTH-1:0]) begin
                        err_d   = 2'd3;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr + ADDR_WIDTH'(1);
                        state_d = (ab || cnt == '0) ? DONE : FETCH;
                    end
                end else if (tmo == T_LAST) begin
                    err_d   = 2'd2;
                    abt_d   = ab;
                    state_d = DONE;
                end
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered decodes of the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            addr             <= '0;
            cnt              <= '0;
            data             <= '0;
            tmo              <= '0;
            abort_p          <= 1'b0;
            err_code         <= 2'd0;
            aborted          <= 1'b0;
            words_done       <= '0;
            src_ready        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            bus.PWRITE       <= 1'b0;
            bus.PENABLE      <= 1'b0;
            bus.DATA_ADDR    <= '0;
            bus.DATA_IN      <= '0;
            bus.FRAC_DECI_EN <= 1'b0;
            bus.IIR_EN       <= 1'b0;
            bus.CIC_EN       <= 1'b0;
            bus.CTRL_EN      <= 1'b0;
        end else begin
            state            <= state_d;
            addr             <= addr_d;
            cnt              <= cnt_d;
            data             <= data_d;
            tmo              <= tmo_d;
            abort_p          <= abort_p_d;
            err_code         <= err_d;
            aborted          <= abt_d;
            words_done       <= wd_d;
            src_ready        <= state_d == FETCH;
            busy             <= state_d != IDLE && state_d != DONE;
            done             <= state_d == DONE;
            bus.PWRITE       <= state_d == SETUP || state_d == ACCESS;
            bus.PENABLE      <= state_d == ACCESS || rd_acc_d;
            bus.DATA_ADDR    <= addr_d;
            bus.DATA_IN      <= data_d;
            bus.FRAC_DECI_EN <= phase_d && addr_d < A_TAPS;
            bus.IIR_EN       <= phase_d && addr_d >= A_TAPS && addr_d < A_CIC;
            bus.CIC_EN       <= phase_d && addr_d == A_CIC;
            bus.CTRL_EN      <= phase_d && addr_d > A_CIC;
        end
    end
endmodule

// File: tb/tb_coeff_load_sequencer.sv
// tb_coeff_load_sequencer: randomized self-checking bench for coeff_load_sequencer
// with a behavioural bank/source model. Honours COEFF_LOAD_VERIFY_EN if defined.
module tb_coeff_load_sequencer;
    localparam int AW = 7, DW = 32, TAPS = 72, ND = 5, TMO = 16;
`ifdef COEFF_LOAD_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int CPW = VERIFY ? 5 : 3;

    logic clk = 0, rst_n = 0, start = 0, abort = 0, src_valid = 0;
    logic src_ready, busy, done, aborted;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0] word_count = '0, words_done;
    logic [DW-1:0] src_data = '0;
    logic [1:0] err_code;
    int checks = 0, errors = 0;

    coeff_load_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    coeff_load_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .bus(bus_if.master),
        .busy(busy), .done(done), .err_code(err_code), .aborted(aborted),
        .words_done(words_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_watchdog time=%0t required=finish earlier", $time);
        $fatal(1, "watchdog");
    end

    typedef struct { int a; logic [DW-1:0] d; logic [3:0] e; } wr_t;
    wr_t wr_q[$];
    logic [DW-1:0] src_q[$], exp_d[$];
    logic [DW-1:0] mem [0:127];
    int rdy_lat = 0, stall_idx = -1, corrupt_addr = -1, nwr = 0, acc_cnt = 0, pen_run = 0, pen_max = 0;
    bit pen_seen = 0, src_on = 1, gaps = 0;

    function automatic logic [3:0] region(input int a);
        return a < TAPS ? 4'b1000 : a < TAPS + 3 * ND ? 4'b0100 : a == TAPS + 3 * ND ? 4'b0010 : 4'b0001;
    endfunction

    function automatic int bad_writes(input int b);
        int n = 0;
        foreach (wr_q[i])
            if (i >= exp_d.size() || wr_q[i].a != b + i || wr_q[i].d !== exp_d[i] || wr_q[i].e !== region(b + i)) n++;
        return n;
    endfunction

    // bank model: PREADY after rdy_lat access cycles, optional stall and readback corruption
    always @(negedge clk) begin : bank
        logic [3:0] en;
        logic [DW-1:0] rd;
        en = {bus_if.FRAC_DECI_EN, bus_if.IIR_EN, bus_if.CIC_EN, bus_if.CTRL_EN};
        if (bus_if.PWRITE || bus_if.PENABLE) begin
            checks++;
            if (en !== region(int'(bus_if.DATA_ADDR))) begin
                errors++;
                $display("FAIL bus_enable addr=%0d got=%b exp=%b", bus_if.DATA_ADDR, en, region(int'(bus_if.DATA_ADDR)));
            end
        end else if (!busy) begin
            checks++;
            if (en !== 4'b0) begin errors++; $display("FAIL idle_enable got=%b exp=0000", en); end
        end
        if (bus_if.PENABLE) begin
            pen_seen = 1;
            pen_run++;
            if (acc_cnt >= rdy_lat && !(bus_if.PWRITE && nwr == stall_idx)) begin
                bus_if.PREADY = 1'b1;
                if (bus_if.PWRITE) begin
                    mem[bus_if.DATA_ADDR] = bus_if.DATA_IN;
                    wr_q.push_back('{int'(bus_if.DATA_ADDR), bus_if.DATA_IN, en});
                    nwr++;
                end else begin
                    rd = $urandom;
                    rd[19:0] = mem[bus_if.DATA_ADDR][19:0] ^ (int'(bus_if.DATA_ADDR) == corrupt_addr ? 20'h1 : 20'h0);
                    bus_if.PRDATA = rd;
                end
                acc_cnt = 0;
            end else begin
                bus_if.PREADY = 1'b0;
                acc_cnt++;
            end
        end else begin
            bus_if.PREADY = 1'b0;
            acc_cnt = 0;
            if (pen_run > pen_max) pen_max = pen_run;
            pen_run = 0;
        end
    end

    initial begin
        bus_if.PREADY = 1'b0;
        bus_if.PRDATA = '0;
    end

    always @(negedge clk) begin
        src_valid = src_on && src_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0);
        src_data  = src_q.size() > 0 ? src_q[0] : '0;
    end

    always @(posedge clk) if (src_valid && src_ready) void'(src_q.pop_front());

    task automatic new_load(input int lat, input bit g, input int n);
        logic [DW-1:0] w;
        wr_q.delete(); exp_d.delete(); src_q.delete();
        nwr = 0; pen_max = 0; pen_run = 0; pen_seen = 0; rdy_lat = lat; gaps = g; src_on = 1;
        repeat (n) begin
            w = $urandom;
            src_q.push_back(w);
            exp_d.push_back(w);
        end
    endtask

    task automatic launch(input int b, input int n);
        @(negedge clk);
        base_addr = AW'(b); word_count = (AW+1)'(n); start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        checks++;
        if (!done) begin errors++; $display("FAIL done_timeout waited=%0d required=done pulse", cyc); end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({src_ready, busy, done, aborted, err_code} !== 6'b0) begin errors++; $display("FAIL reset_status got=%b exp=0", {src_ready, busy, done, aborted, err_code}); end
        checks++;
        if ({bus_if.PWRITE, bus_if.PENABLE, bus_if.FRAC_DECI_EN, bus_if.IIR_EN, bus_if.CIC_EN, bus_if.CTRL_EN} !== 6'b0) begin
            errors++; $display("FAIL reset_bus got=%b exp=0", {bus_if.PWRITE, bus_if.PENABLE, bus_if.FRAC_DECI_EN, bus_if.IIR_EN, bus_if.CIC_EN, bus_if.CTRL_EN});
        end
        checks++;
        if (words_done !== '0 || bus_if.DATA_ADDR !== '0 || bus_if.DATA_IN !== '0) begin errors++; $display("FAIL reset_regs words_done=%0d addr=%0d exp=0", words_done, bus_if.DATA_ADDR); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_full_frac;
        int cyc;
        new_load(0, 0, 72);
        launch(0, 72);
        wait_done(cyc);
        checks++; if (cyc != 72 * CPW) begin errors++; $display("FAIL frac_cycles got=%0d exp=%0d", cyc, 72 * CPW); end
        checks++; if (wr_q.size() != 72 || bad_writes(0) != 0) begin errors++; $display("FAIL frac_writes count=%0d bad=%0d exp count=72 bad=0", wr_q.size(), bad_writes(0)); end
        checks++; if (words_done !== 8'd72 || err_code !== 2'd0 || aborted !== 1'b0) begin errors++; $display("FAIL frac_status wd=%0d err=%0d ab=%0d exp 72/0/0", words_done, err_code, aborted); end
        checks++; if (src_q.size() != 0) begin errors++; $display("FAIL frac_src_left got=%0d exp=0", src_q.size()); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL frac_done_pulse done=%b busy=%b exp 0/0", done, busy); end
    endtask

    task automatic test_region_cross;
        int cyc;
        new_load($urandom_range(0, 2), 1, 4);
        launch(85, 4);
        wait_done(cyc);
        checks++; if (wr_q.size() != 4 || bad_writes(85) != 0) begin errors++; $display("FAIL cross_writes count=%0d bad=%0d exp count=4 bad=0", wr_q.size(), bad_writes(85)); end
        checks++; if (words_done !== 8'd4 || err_code !== 2'd0) begin errors++; $display("FAIL cross_status wd=%0d err=%0d exp 4/0", words_done, err_code); end
    endtask

    task automatic test_random_loads;
        int cyc, b, n;
        for (int k = 0; k < 5; k++) begin
            b = $urandom_range(0, 95);
            n = $urandom_range(1, (96 - b) < 8 ? 96 - b : 8);
            new_load($urandom_range(0, 2), 1, n);
            launch(b, n);
            wait_done(cyc);
            checks++; if (wr_q.size() != n || bad_writes(b) != 0) begin errors++; $display("FAIL rand_writes base=%0d count=%0d got=%0d bad=%0d", b, n, wr_q.size(), bad_writes(b)); end
            checks++; if (words_done !== (AW+1)'(n) || err_code !== 2'd0 || aborted !== 1'b0) begin errors++; $display("FAIL rand_status wd=%0d err=%0d ab=%0d exp %0d/0/0", words_done, err_code, aborted, n); end
        end
    endtask

    task automatic test_range_zero;
        int cyc;
        new_load(0, 0, 10);
        launch(90, 10);
        wait_done(cyc);
        checks++; if (cyc != 0 || err_code !== 2'd1) begin errors++; $display("FAIL range_err cyc=%0d err=%0d exp 0/1", cyc, err_code); end
        @(negedge clk);
        checks++; if (pen_seen || wr_q.size() != 0 || words_done !== '0) begin errors++; $display("FAIL range_nobus pen=%0d writes=%0d wd=%0d exp 0/0/0", pen_seen, wr_q.size(), words_done); end
        new_load(0, 0, 0);
        launch(5, 0);
        wait_done(cyc);
        checks++; if (cyc != 0 || err_code !== 2'd0 || words_done !== '0) begin errors++; $display("FAIL zero_count cyc=%0d err=%0d wd=%0d exp 0/0/0", cyc, err_code, words_done); end
        new_load(0, 0, 1);
        launch(95, 1);
        wait_done(cyc);
        checks++; if (err_code !== 2'd0 || wr_q.size() != 1 || bad_writes(95) != 0) begin errors++; $display("FAIL last_addr err=%0d writes=%0d exp 0/1", err_code, wr_q.size()); end
        new_load(0, 0, 3);
        launch(94, 3);
        wait_done(cyc);
        checks++; if (err_code !== 2'd1 || cyc != 0) begin errors++; $display("FAIL over_by_one err=%0d cyc=%0d exp 1/0", err_code, cyc); end
        new_load(0, 0, 96);
        launch(1, 96);
        wait_done(cyc);
        checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL full_shifted err=%0d exp 1", err_code); end
        launch(0, 96);
        wait_done(cyc);
        checks++; if (err_code !== 2'd0 || words_done !== 8'd96 || wr_q.size() != 96 || bad_writes(0) != 0) begin errors++; $display("FAIL full_bank err=%0d wd=%0d writes=%0d exp 0/96/96", err_code, words_done, wr_q.size()); end
    endtask

    task automatic test_timeout;
        int cyc;
        new_load(0, 0, 5);
        stall_idx = 2;
        launch(10, 5);
        wait_done(cyc);
        checks++; if (err_code !== 2'd2 || words_done !== 8'd2 || wr_q.size() != 2) begin errors++; $display("FAIL timeout_status err=%0d wd=%0d writes=%0d exp 2/2/2", err_code, words_done, wr_q.size()); end
        @(negedge clk);
        checks++; if (pen_max != TMO) begin errors++; $display("FAIL timeout_penable_len got=%0d exp=%0d", pen_max, TMO); end
        checks++; if (bus_if.PWRITE !== 1'b0 || bus_if.PENABLE !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_bus_idle pw=%b pe=%b busy=%b exp 0", bus_if.PWRITE, bus_if.PENABLE, busy); end
        checks++; if (src_q.size() != 2) begin errors++; $display("FAIL timeout_src_left got=%0d exp=2", src_q.size()); end
        stall_idx = -1;
    endtask

    task automatic test_abort;
        int cyc, w;
        logic [DW-1:0] x;
        new_load(0, 0, 2);
        launch(20, 5);
        w = 0;
        while (!(nwr == 2 && src_ready) && w < 200) begin @(negedge clk); w++; end
        src_on = 0;
        repeat (3) begin x = $urandom; src_q.push_back(x); exp_d.push_back(x); end
        repeat (3) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        wait_done(cyc);
        checks++; if (cyc != 0 || aborted !== 1'b1 || err_code !== 2'd0) begin errors++; $display("FAIL abort_fetch cyc=%0d ab=%0d err=%0d exp 0/1/0", cyc, aborted, err_code); end
        repeat (4) @(negedge clk);
        checks++; if (words_done !== 8'd2 || wr_q.size() != 2 || src_q.size() != 3) begin errors++; $display("FAIL abort_fetch_writes wd=%0d writes=%0d left=%0d exp 2/2/3", words_done, wr_q.size(), src_q.size()); end
        new_load(3, 0, 5);
        launch(30, 5);
        w = 0;
        while (!bus_if.PENABLE && w < 200) begin @(negedge clk); w++; end
        abort = 1;
        @(negedge clk);
        abort = 0;
        wait_done(cyc);
        checks++; if (aborted !== 1'b1 || err_code !== 2'd0 || words_done !== 8'd1) begin errors++; $display("FAIL abort_access ab=%0d err=%0d wd=%0d exp 1/0/1", aborted, err_code, words_done); end
        checks++; if (wr_q.size() != 1 || bad_writes(30) != 0) begin errors++; $display("FAIL abort_access_write count=%0d exp=1", wr_q.size()); end
        new_load(0, 1, 2);
        @(negedge clk);
        base_addr = 7'd40; word_count = 8'd2; start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        wait_done(cyc);
        checks++; if (aborted !== 1'b0 || words_done !== 8'd2 || wr_q.size() != 2 || bad_writes(40) != 0) begin errors++; $display("FAIL start_beats_abort ab=%0d wd=%0d writes=%0d exp 0/2/2", aborted, words_done, wr_q.size()); end
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        @(negedge clk);
        checks++; if (aborted !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_abort ab=%0d busy=%0d done=%0d exp 0/0/0", aborted, busy, done); end
    endtask

    task automatic test_verify;
        int cyc;
        new_load(0, 0, 10);
        corrupt_addr = 5;
        launch(0, 10);
        wait_done(cyc);
        checks++; if (err_code !== (VERIFY ? 2'd3 : 2'd0)) begin errors++; $display("FAIL verify_err got=%0d exp=%0d", err_code, VERIFY ? 3 : 0); end
        checks++; if (words_done !== (VERIFY ? 8'd6 : 8'd10) || bad_writes(0) != 0) begin errors++; $display("FAIL verify_words got=%0d exp=%0d", words_done, VERIFY ? 6 : 10); end
        corrupt_addr = -1;
    endtask

    task automatic test_reset_midload;
        int w;
        bit seen_done;
        new_load(6, 0, 8);
        launch(0, 8);
        w = 0;
        while (!bus_if.PENABLE && w < 200) begin @(negedge clk); w++; end
        #2 rst_n = 0;
        #1;
        checks++; if (bus_if.PENABLE !== 1'b0 || bus_if.PWRITE !== 1'b0 || busy !== 1'b0 || bus_if.FRAC_DECI_EN !== 1'b0) begin errors++; $display("FAIL reset_drop pe=%b pw=%b busy=%b exp 0", bus_if.PENABLE, bus_if.PWRITE, busy); end
        seen_done = 0;
        repeat (3) begin @(negedge clk); seen_done |= done; end
        rst_n = 1;
        repeat (3) begin @(negedge clk); seen_done |= done; end
        checks++; if (seen_done || words_done !== '0) begin errors++; $display("FAIL reset_no_done done_seen=%0d wd=%0d exp 0/0", seen_done, words_done); end
    endtask

    initial begin
        test_reset;
        test_full_frac;
        test_region_cross;
        test_random_loads;
        test_range_zero;
        test_timeout;
        test_abort;
        test_verify;
        test_reset_midload;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
